fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the control unit and decoder. It owns the PC register and issues word fetches to instruction memory over a req/ready + rvalid handshake. It presents one instruction at a time with valid/ready and applies the redirect (pcsrc/jump) computed for the instruction being consumed. Flush aborts any in-flight fetch and discards its response.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.
CNT_W, 32, width of fetch performance counter.

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
imem_req  out  1  fetch request valid.
imem_addr  out  32  word-aligned fetch address.
imem_ready  in  1  memory accepts request this cycle.
imem_rvalid  in  1  read data valid; at least 1 cycle after acceptance.
imem_rdata  in  32  instruction word.
instr  out  32  held instruction to decoder/controller.
instr_pc  out  32  PC of held instruction.
pc_plus4  out  32  instr_pc + 4, mod 2^32.
instr_valid  out  1  instr/instr_pc/pc_plus4 are valid.
instr_ready  in  1  downstream consumes instruction this cycle.
pcsrc  in  1  taken branch for consumed instruction.
jump  in  1  jump for consumed instruction.
branch_target  in  32  branch destination.
jump_target  in  32  jump destination.
flush  in  1  abort; restart at flush_pc.
flush_pc  in  32  restart address.
fetch_count  out  CNT_W  count of instructions delivered.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr=0, instr_pc=0, pc_plus4=0, instr_valid=0, fetch_count=0.
- States: IDLE, FETCH, WAIT, HOLD, DROP. At most one outstanding request.
- IDLE: one cycle after reset release -> FETCH.
- FETCH: imem_req=1, imem_addr=fetch_pc. imem_ready=1 -> WAIT; else stay, address held stable.
- WAIT: imem_rvalid=1 -> register instr=imem_rdata, instr_pc=fetch_pc, pc_plus4=fetch_pc+4, instr_valid=1, fetch_count+=1 (wraps), -> HOLD. Any rvalid outside WAIT/DROP is ignored.
- HOLD: instr_valid=1, outputs stable. On instr_valid&instr_ready: next fetch_pc = jump_target if jump; else branch_target if pcsrc; else pc_plus4 (jump wins when both set). instr_valid drops next cycle, -> FETCH. pcsrc/jump are sampled only on that consume cycle.
- Next-PC targets: bits [1:0] forced to 0. Sequential 32'hFFFF_FFFC+4 wraps to 0.
- Latency: minimum 3 cycles from FETCH entry to instr_valid (FETCH accept, WAIT with rvalid, HOLD). Throughput with zero-wait memory: one instruction per 3 cycles.
- flush (highest priority, any state except IDLE): fetch_pc=flush_pc&~3, instr_valid=0 next cycle, fetch_count unchanged. From WAIT without rvalid the same cycle -> DROP. From WAIT with rvalid the same cycle, or from FETCH/HOLD -> FETCH. A FETCH-cycle acceptance coincident with flush is treated as outstanding and also -> DROP.
- DROP: imem_req=0. Wait for rvalid, discard data, -> FETCH. A flush while in DROP only updates fetch_pc.
- Flush and consume in the same cycle: flush wins; redirect ignored.
- Reset mid-operation: immediate return to reset values. Any memory response still in flight after reset is the memory's responsibility; fetch_unit ignores rvalid in IDLE/FETCH.

Decomposition:
- Shared package mips_pkg: fetch state enum (IDLE, FETCH, WAIT, HOLD, DROP), PC_W=32, default RESET_PC, constant WORD_MASK=~32'h3.
- Sub-module pc_next_sel: combinational priority mux (flush > jump > pcsrc > pc_plus4) with alignment masking. Instantiated once.

Test Plan:
1. Reset release, memory ready=1, rvalid 1 cycle later with 32'h2010_0005 -> imem_addr=0 on first FETCH, instr=32'h2010_0005, instr_pc=0, pc_plus4=4, instr_valid in 3rd cycle, fetch_count=1.
2. Sequential stream, rvalid latency 3, instr_ready=1 -> addrs 0,4,8,C in order; fetch_count=4; never two requests outstanding.
3. instr_ready held 0 for 5 cycles in HOLD -> instr/instr_pc stable, imem_req=0. Consume at 6th cycle -> next imem_addr=instr_pc+4.
4. Consume at instr_pc=0x10 with pcsrc=1, branch_target=0x40 -> next imem_addr=0x40. With jump=1, jump_target=0x80 also set -> 0x80. With branch_target=0x43 -> 0x40.
5. flush with flush_pc=0x200 in WAIT before rvalid; stale rvalid arrives 2 cycles later -> DROP, stale data never on instr, instr_valid stays 0, next imem_addr=0x200, fetch_count unchanged.
6. Fetch at 32'hFFFF_FFFC, consume with no redirect -> pc_plus4=0, next imem_addr=0. Assert reset_n=0 mid-WAIT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch slice: PC width, default
// reset vector, word-alignment mask and the fetch sequencer states.
package mips_pkg;

  localparam int PC_W = 32;

  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Clears the byte-offset bits so every fetch address is word aligned.
  localparam logic [PC_W-1:0] WORD_MASK = ~32'h0000_0003;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DROP  = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next fetch-PC selection: flush beats jump, jump beats taken branch,
// otherwise fall through to the sequential PC. Result is always word aligned.
module pc_next_sel
  import mips_pkg::*;
(
  input  logic            flush,
  input  logic [PC_W-1:0] flush_pc,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  input  logic            pcsrc,
  input  logic [PC_W-1:0] branch_target,
  input  logic [PC_W-1:0] seq_pc,
  output logic [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] raw_pc;

  // Priority mux over the redirect sources, then drop the byte offset.
  always_comb begin
    raw_pc = seq_pc;
    if (flush) begin
      raw_pc = flush_pc;
    end else if (jump) begin
      raw_pc = jump_target;
    end else if (pcsrc) begin
      raw_pc = branch_target;
    end
    next_pc = raw_pc & WORD_MASK;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one word fetch at a time over
// a req/ready + rvalid handshake, holds the returned instruction for the
// decoder until it is consumed, and applies redirects and flushes.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic [31:0]      instr_pc,
  output logic [31:0]      pc_plus4,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             pcsrc,
  input  logic             jump,
  input  logic [31:0]      branch_target,
  input  logic [31:0]      jump_target,
  input  logic             flush,
  input  logic [31:0]      flush_pc,
  output logic [CNT_W-1:0] fetch_count
);

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] sel_pc;
  logic            flush_act;
  logic            consume;
  logic            capture;
  logic            pc_load;

  // Flush has no effect before the first fetch has been started.
  assign flush_act = flush && (state != IDLE);
  // A consume only counts while an instruction is actually being held.
  assign consume   = (state == HOLD) && instr_valid && instr_ready;
  // A response is kept only if nothing aborted it in the same cycle.
  assign capture   = (state == WAIT) && imem_rvalid && !flush_act;
  assign pc_load   = flush_act || consume;

  assign imem_req  = (state == FETCH);
  assign imem_addr = fetch_pc;

  pc_next_sel u_pc_next_sel (
    .flush         (flush_act),
    .flush_pc      (flush_pc),
    .jump          (jump),
    .jump_target   (jump_target),
    .pcsrc         (pcsrc),
    .branch_target (branch_target),
    .seq_pc        (pc_plus4),
    .next_pc       (sel_pc)
  );

  // Sequencer next state; an accepted request is always outstanding, so an
  // acceptance coincident with a flush still has to be drained in DROP.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        state_next = FETCH;
      end
      FETCH: begin
        if (imem_ready) begin
          state_next = flush_act ? DROP : WAIT;
        end
      end
      WAIT: begin
        if (flush_act) begin
          state_next = imem_rvalid ? FETCH : DROP;
        end else if (imem_rvalid) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (flush_act || consume) begin
          state_next = FETCH;
        end
      end
      DROP: begin
        if (imem_rvalid) begin
          state_next = FETCH;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Fetch PC moves only on a flush or when the held instruction is consumed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
    end else if (pc_load) begin
      fetch_pc <= sel_pc;
    end
  end

  // Instruction holding registers, loaded only from a kept response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr    <= '0;
      instr_pc <= '0;
      pc_plus4 <= '0;
    end else if (capture) begin
      instr    <= imem_rdata;
      instr_pc <= fetch_pc;
      pc_plus4 <= fetch_pc + 32'd4;
    end
  end

  // Valid flag: raised on capture, dropped by consume or flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_valid <= 1'b0;
    end else if (capture) begin
      instr_valid <= 1'b1;
    end else if (flush_act || consume) begin
      instr_valid <= 1'b0;
    end
  end

  // Delivered-instruction counter, free-running with wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count <= '0;
    end else if (capture) begin
      fetch_count <= fetch_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural memory, a PC-level reference
// model that queues the expected fetch address of the next delivered
// instruction, and a monitor that checks every delivered instruction.
module tb_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        instr_ready;
  logic        pcsrc;
  logic        jump;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] fetch_count;

  int          checks = 0;
  int          errors = 0;
  int          deliveries = 0;
  logic [31:0] exp_q[$];
  logic [31:0] cur_pc = 32'h0;
  bit          fast_mem = 1'b1;
  bit          mem_pending = 1'b0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .pc_plus4      (pc_plus4),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .pcsrc         (pcsrc),
    .jump          (jump),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .fetch_count   (fetch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents: a bijective scramble of the address, 0 -> 32'h2010_0005.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h2010_0005;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0: v = $urandom;
      1: v = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      2: v = 32'h0000_0200;
      default: v = 32'($urandom_range(0, 255));
    endcase
    return v;
  endfunction

  // Random downstream/redirect stimulus for one cycle plus the reference
  // model update: the next delivered instruction comes from flush_pc after a
  // flush, otherwise from the redirect chosen when the held one is consumed.
  task automatic rand_step(input bit allow_flush);
    logic [31:0] nxt;
    instr_ready   = ($urandom_range(0, 2) != 0);
    pcsrc         = ($urandom_range(0, 4) == 0);
    jump          = ($urandom_range(0, 4) == 0);
    branch_target = rand_target();
    jump_target   = rand_target();
    flush_pc      = rand_target();
    flush         = allow_flush && ($urandom_range(0, 15) == 0);
    if (flush) begin
      exp_q.delete();
      exp_q.push_back(flush_pc & ~32'h3);
    end else if (instr_valid && instr_ready) begin
      if (jump)       nxt = jump_target;
      else if (pcsrc) nxt = branch_target;
      else            nxt = cur_pc + 32'd4;
      exp_q.push_back(nxt & ~32'h3);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h0);
    chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_fetch_count", fetch_count, 32'h0);
  endtask

  // Memory: single outstanding request, response 1..4 cycles after
  // acceptance, spurious rvalid pulses while nothing is outstanding.
  initial begin : memory
    logic [31:0] paddr;
    int          lat;
    bit          was_pending;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    paddr       = 32'h0;
    lat         = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset_n) begin
        mem_pending = 1'b0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
      end else begin
        was_pending = mem_pending;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (was_pending) begin
          if (lat == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memf(paddr);
            mem_pending = 1'b0;
          end else begin
            lat--;
          end
        end else if ($urandom_range(0, 7) == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = 32'hDEAD_0000 | 32'($urandom_range(0, 65535));
        end
        imem_ready = fast_mem ? 1'b1 : ($urandom_range(0, 1) == 1);
        if (imem_req) begin
          chk("single_outstanding", {31'h0, mem_pending}, 32'h0);
          if (imem_ready) begin
            mem_pending = 1'b1;
            paddr       = imem_addr;
            lat         = fast_mem ? 0 : int'($urandom_range(0, 3));
          end
        end
      end
    end
  end

  // Monitor: on each new instruction, pop the expected fetch address and
  // check the full presentation; while held, check it stays put.
  initial begin : monitor
    logic        prev_valid;
    logic [31:0] held_instr;
    logic [31:0] held_pc;
    logic [31:0] exp_pc;
    int          exp_count;
    int          idle_cycles;
    prev_valid  = 1'b0;
    held_instr  = 32'h0;
    held_pc     = 32'h0;
    exp_count   = 0;
    idle_cycles = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_valid  = 1'b0;
        exp_count   = 0;
        idle_cycles = 0;
      end else begin
        idle_cycles++;
        if (instr_valid && !prev_valid) begin
          idle_cycles = 0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_instr: got pc %h instr %h expected none", instr_pc, instr);
          end else begin
            exp_pc = exp_q.pop_front();
            exp_count++;
            deliveries++;
            chk("instr", instr, memf(exp_pc));
            chk("instr_pc", instr_pc, exp_pc);
            chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
            chk("fetch_count", fetch_count, 32'(exp_count));
            cur_pc = exp_pc;
            $display("txn %0d: pc=%h instr=%h count=%0d", exp_count, instr_pc, instr, fetch_count);
          end
          held_instr = instr;
          held_pc    = instr_pc;
        end else if (instr_valid) begin
          chk("hold_instr", instr, held_instr);
          chk("hold_pc", instr_pc, held_pc);
        end
        if (instr_valid) begin
          chk("no_req_in_hold", {31'h0, imem_req}, 32'h0);
        end
        if (idle_cycles > 300) begin
          checks++;
          errors++;
          $display("FAIL stall: got no instruction for %0d cycles expected delivery", idle_cycles);
          idle_cycles = 0;
        end
        prev_valid = instr_valid;
      end
    end
  end

  // Directed start-up and mid-run reset around long random phases.
  initial begin : driver
    int first_cyc;
    bit got_wait;
    reset_n       = 1'b0;
    instr_ready   = 1'b0;
    pcsrc         = 1'b0;
    jump          = 1'b0;
    branch_target = 32'h0;
    jump_target   = 32'h0;
    flush         = 1'b0;
    flush_pc      = 32'h0;
    exp_q.push_back(32'h0);

    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs();
    reset_n = 1'b1;

    // First fetch: address 0, instruction presented in the third cycle.
    first_cyc = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      #1;
      if (c == 1) begin
        chk("first_req", {31'h0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'h0);
      end
      if (instr_valid) begin
        first_cyc = c;
        break;
      end
    end
    chk("first_latency", 32'(first_cyc), 32'd3);

    for (int c = 0; c < 2500; c++) begin
      if (c == 40) fast_mem = 1'b0;
      rand_step(1'b1);
      @(negedge clk);
      #1;
    end

    // Reset while a request is outstanding.
    got_wait = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (mem_pending && !imem_req && !instr_valid) begin
        got_wait = 1'b1;
        break;
      end
      rand_step(1'b0);
      @(negedge clk);
      #1;
    end
    chk("reached_wait", {31'h0, got_wait}, 32'h1);
    flush = 1'b0;
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    exp_q.push_back(32'h0);
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    #1;
    instr_ready = 1'b0;
    flush       = 1'b0;
    reset_n     = 1'b1;
    @(negedge clk);
    #1;

    for (int c = 0; c < 1500; c++) begin
      rand_step(1'b1);
      @(negedge clk);
      #1;
    end

    chk("enough_deliveries", {31'h0, deliveries > 200}, 32'h1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
